// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button event front end.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_HELD,
    ST_REPEAT
  } btn_state_e;

  function automatic int BTN_ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce filter and hold/auto-repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 0,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic clk,
  input  logic a_rst,
  input  logic s_rst,
  input  logic btn_raw,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic              INV       = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_lvl;
  logic                   accept;
  logic [DB_W-1:0]        db_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  btn_state_e             fsm;

  assign sync_lvl = sync_pipe[SYNC_STAGES-1] ^ INV;
  assign accept   = (sync_lvl != btn_state) && (db_cnt == DB_LAST);

  // Stage: synchroniser and debounce filter
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      sync_pipe <= '0;
      db_cnt    <= '0;
      btn_state <= 1'b0;
    end else if (s_rst) begin
      sync_pipe <= '0;
      db_cnt    <= '0;
      btn_state <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], btn_raw};
      if (sync_lvl == btn_state) begin
        db_cnt <= '0;
      end else if (accept) begin
        btn_state <= sync_lvl;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Stage: hold FSM, strobes registered alongside the debounced level
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      fsm           <= ST_IDLE;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else if (s_rst) begin
      fsm           <= ST_IDLE;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (accept && btn_state) begin
        release_pulse <= 1'b1;
        fsm           <= ST_IDLE;
        hold_cnt      <= '0;
      end else begin
        case (fsm)
          ST_IDLE: begin
            if (accept) begin
              press_pulse <= 1'b1;
              fsm         <= ST_PRESSED;
              hold_cnt    <= '0;
            end
          end
          ST_PRESSED: begin
            if (hold_cnt == LONG_LAST) begin
              long_pulse <= 1'b1;
              fsm        <= ST_HELD;
              hold_cnt   <= '0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          ST_HELD, ST_REPEAT: begin
            // HELD counts its first repeat cycle too, so the period starts at long_pulse
            if (REPEAT_CYCLES > 0) begin
              fsm <= ST_REPEAT;
              if (hold_cnt == REP_LAST) begin
                repeat_pulse <= 1'b1;
                hold_cnt     <= '0;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end
          end
          default: begin
            fsm      <= ST_IDLE;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_event_unit.sv
// Multi-channel button front end with a priority-encoded valid/ready press-event port.
module btn_event_unit
  import btn_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 0,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic                        clk,
  input  logic                        a_rst,
  input  logic                        s_rst,
  input  logic [N_BTN-1:0]            btn_raw,
  output logic [N_BTN-1:0]            btn_state,
  output logic [N_BTN-1:0]            press_pulse,
  output logic [N_BTN-1:0]            release_pulse,
  output logic [N_BTN-1:0]            long_pulse,
  output logic [N_BTN-1:0]            repeat_pulse,
  output logic                        event_valid,
  output logic [BTN_ID_W(N_BTN)-1:0]  event_id,
  input  logic                        event_ready
);

  localparam int ID_W = BTN_ID_W(N_BTN);

  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] clr;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk           (clk),
      .a_rst         (a_rst),
      .s_rst         (s_rst),
      .btn_raw       (btn_raw[i]),
      .btn_state     (btn_state[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  // Lowest pending index wins
  always_comb begin
    event_id = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend[i]) event_id = ID_W'(i);
    end
  end

  assign event_valid = |pend;
  assign clr         = (event_valid && event_ready) ? (N_BTN'(1) << event_id) : '0;

  // Stage: pending register; a coincident press re-sets the bit being accepted
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      pend <= '0;
    end else if (s_rst) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr) | press_pulse;
    end
  end

endmodule

// File: doc/btn_event_unit.md
# btn_event_unit

Parametrised multi-channel push-button front end for the SPI core's user controls. Each of `N_BTN` raw pad inputs is synchronised, debounced and tracked by a per-channel hold state machine. The block emits one-cycle press, release, long-press and auto-repeat strobes. It also provides a priority-encoded, valid/ready press-event port that the SPI control logic consumes for commands such as next-count and start-send.

## Interface
- `N_BTN`, 2: number of button channels, 1..16.
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2.
- `ACTIVE_LOW`, 0: 1 = pad reads 0 when pressed; inversion is applied after the synchroniser.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required to accept a level change, ≥1.
- `LONG_CYCLES`, 16: cycles from the accepted press to `long_pulse`, > `DEBOUNCE_CYCLES`.
- `REPEAT_CYCLES`, 0: auto-repeat period after the long press; 0 disables repeat.

Ports:
- `clk` in 1: clock.
- `a_rst` in 1: reset, asynchronous, active-high.
- `s_rst` in 1: synchronous clear, active-high; same effect as `a_rst` at the next edge.
- `btn_raw` in `N_BTN`: asynchronous pad inputs.
- `btn_state` out `N_BTN`: debounced level; 1 = pressed.
- `press_pulse` out `N_BTN`: 1-cycle strobe when a press is accepted.
- `release_pulse` out `N_BTN`: 1-cycle strobe when a release is accepted.
- `long_pulse` out `N_BTN`: 1-cycle strobe when the long-press threshold is reached.
- `repeat_pulse` out `N_BTN`: 1-cycle strobe every `REPEAT_CYCLES` after `long_pulse`.
- `event_valid` out 1: at least one press event is pending.
- `event_id` out `max(1,$clog2(N_BTN))`: channel index of the presented event.
- `event_ready` in 1: consumer accepts the event.

## Operation
- **Reset** (`a_rst` or `s_rst`): all outputs 0, synchronisers 0, counters 0, all FSMs in IDLE, pending bits cleared.
- **Conditioning:** `sync_lvl` = synchroniser output, XOR'd with `ACTIVE_LOW`.
- **Debounce counter** `db_cnt`:
  - Increments while `sync_lvl != btn_state`.
  - Clears when they are equal.
  - When `db_cnt == DEBOUNCE_CYCLES-1` and they still differ, `btn_state` toggles at the next edge and `db_cnt` clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- **Per-channel FSM** (`btn_state_e`): IDLE, PRESSED, HELD, REPEAT.
  - IDLE→PRESSED on an accepted press: `press_pulse` is registered in the same cycle `btn_state` rises, and `hold_cnt` is cleared.
  - PRESSED: `hold_cnt` increments. At `hold_cnt == LONG_CYCLES-1` the FSM goes to HELD and `long_pulse` is issued.
  - HELD→REPEAT immediately when `REPEAT_CYCLES > 0`; otherwise the FSM stays in HELD.
  - REPEAT: `hold_cnt` reloads to 0 and issues `repeat_pulse` each time it reaches `REPEAT_CYCLES-1`.
  - Any state → IDLE on an accepted release: `release_pulse` is issued and `hold_cnt` is cleared.
  - `hold_cnt` width is `$clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1)`; it never wraps outside these rules.
- **Event port:**
  - `pend[i]` is set by `press_pulse[i]`.
  - `event_valid = |pend`.
  - `event_id` = lowest index with `pend` set.
  - `event_valid && event_ready` clears `pend[event_id]` only.
  - If set and clear of the same bit coincide, set wins; the bit stays 1.
  - A second press on a channel whose bit is already pending is merged (not counted).
  - `event_id` and `event_valid` are stable while `event_valid && !event_ready`, except when a lower-index press arrives, which may pre-empt the presented id.

## Timing
- Pad edge to `btn_state`/`press_pulse`: `SYNC_STAGES + DEBOUNCE_CYCLES` cycles, with the pad level held stable throughout.
- `long_pulse`: `LONG_CYCLES` cycles after `press_pulse`.
- First `repeat_pulse`: `REPEAT_CYCLES` cycles after `long_pulse`, then periodic.
- `press_pulse` to `event_valid`: 1 cycle; `pend` is registered.
- Handshake clear takes effect at the next edge, so the next pending id is presented 1 cycle after acceptance.
- Channels are fully independent. Simultaneous presses raise multiple `press_pulse` bits in the same cycle, and events are served in ascending index order.
- Reset mid-hold: no `release_pulse` is generated. After reset, a still-pressed button re-debounces from IDLE and produces a fresh `press_pulse`.

## Structure
- Package `btn_pkg`: `btn_state_e` enum and the `BTN_ID_W` width function.
- Sub-module `btn_channel`: synchroniser + debounce + FSM + `hold_cnt`, instantiated `N_BTN` times via generate.
- The top-level holds the `pend` register and the priority encoder.

## Test plan
All scenarios use `N_BTN=4`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`, `LONG_CYCLES=16`, `REPEAT_CYCLES=8`, `ACTIVE_LOW=0`.
- **Clean press:** `btn_raw[1]` 0→1 held 40 cycles → `press_pulse[1]` exactly 6 cycles after the edge, and `long_pulse[1]` 16 cycles later. Then `repeat_pulse[1]` at +8 and +16 after `long_pulse` and every 8 cycles thereafter while held; release → `release_pulse[1]` 6 cycles after the falling edge.
- **Bounce:** `btn_raw[0]` toggles with 1–3-cycle pulses for 20 cycles, then settles high → exactly one `press_pulse[0]`, 6 cycles after settling; no `release_pulse`.
- **Simultaneous:** `btn_raw[3]` and `btn_raw[0]` rise together with `event_ready=0` → `event_valid=1`, `event_id=0`. Assert `event_ready` for one cycle → `event_id=3` the next cycle; second accept → `event_valid=0`.
- **Merge / set-wins:** a press on ch2 while `pend[2]=1` → still a single event. A press coinciding with acceptance of ch2 → `pend[2]` stays 1.
- **Reset:** `a_rst` pulse while ch1 is in REPEAT → all outputs 0 immediately. With the pad still high → a new `press_pulse[1]` 6 cycles after release of reset.
- **ACTIVE_LOW=1 / REPEAT_CYCLES=0:** pad 1→0 → press accepted. Held 40 cycles → one `long_pulse` and no `repeat_pulse`.
